outerprodrc_acc: RTL

//  Temporal accumulator directly downstream of the rate-coded outer-product array.

---
 rtl/outerprodrc_acc.sv | 122 ++++++++++++
 1 files changed

// File: rtl/outerprodrc_acc.sv
// Temporal accumulator for the rate-coded outer-product array.
// It sums a signed ROWNUM x COLNUM partial-sum tile over a CYCLES-sample window.
// The finished tile is presented on a valid/ready output register.
// The next window accumulates while the consumer still holds the previous tile.
module outerprodrc_acc #(
    parameter int ROWNUM     = 2,
    parameter int COLNUM     = 2,
    parameter int INBITWIDTH = 8,
    parameter int CYCLES     = 256,
    parameter int ACCWIDTH   = 16
) (
    input  logic                                iClk,
    input  logic                                iRstN,
    input  logic                                iEn,
    input  logic                                iClr,
    input  logic [ROWNUM*COLNUM*INBITWIDTH-1:0] iData,
    input  logic                                iReady,
    output logic [ROWNUM*COLNUM*ACCWIDTH-1:0]   oData,
    output logic                                oValid,
    output logic                                oOvf,
    output logic [$clog2(CYCLES)-1:0]           oCnt
);

    localparam int NE = ROWNUM * COLNUM;
    localparam int CW = $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    ostate_t                      state, state_nxt;
    logic [ACCWIDTH-1:0]          acc [NE];
    logic [ACCWIDTH-1:0]          sum [NE];
    logic [NE*ACCWIDTH-1:0]       sum_flat;
    logic [CW-1:0]                cnt;
    logic [NE*ACCWIDTH-1:0]       data_q;
    logic                         ovf_q;
    logic                         sample;
    logic                         win_end;
    logic                         load_out;
    logic                         set_ovf;

    // A clear wins over a sample arriving in the same cycle.
    // For that reason, a clear on the last slot does not end the window.
    assign sample  = iEn && !iClr;
    assign win_end = sample && (cnt == LAST);

    // Per-element running sum including this cycle's sign-extended sample
    always_comb begin
        sum_flat = '0;
        for (int unsigned e = 0; e < NE; e++) begin
            sum[e] = acc[e] + ACCWIDTH'($signed(iData[e*INBITWIDTH +: INBITWIDTH]));
            sum_flat[e*ACCWIDTH +: ACCWIDTH] = sum[e];
        end
    end

    // Accumulators: the final sample of a window goes to the output path.
    // The accumulator restarts at zero, so a back-to-back sample needs no bubble.
    always_ff @(posedge iClk) begin
        if (!iRstN || iClr || win_end) begin
            for (int unsigned e = 0; e < NE; e++) acc[e] <= '0;
        end else if (iEn) begin
            for (int unsigned e = 0; e < NE; e++) acc[e] <= sum[e];
        end
    end

    // Sample counter within the current window
    always_ff @(posedge iClk) begin
        if (!iRstN || iClr || win_end) cnt <= '0;
        else if (iEn)                  cnt <= cnt + CW'(1);
    end

    // Output state register
    always_ff @(posedge iClk) begin
        if (!iRstN) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Output next-state logic. A full slot with no acceptance drops the new result.
    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        set_ovf   = 1'b0;
        case (state)
            EMPTY: begin
                if (win_end) begin
                    load_out  = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (iReady) begin
                    if (win_end) load_out = 1'b1;
                    else         state_nxt = EMPTY;
                end else if (win_end) begin
                    set_ovf = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Output data register; it holds while the result is waiting for the consumer.
    always_ff @(posedge iClk) begin
        if (!iRstN)        data_q <= '0;
        else if (load_out) data_q <= sum_flat;
    end

    // Sticky drop flag; only reset clears it
    always_ff @(posedge iClk) begin
        if (!iRstN)       ovf_q <= 1'b0;
        else if (set_ovf) ovf_q <= 1'b1;
    end

    assign oData  = data_q;
    assign oValid = (state == FULL);
    assign oOvf   = ovf_q;
    assign oCnt   = cnt;

endmodule
